// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory slave with a valid/ready request
// channel and a valid/ready response channel. One request is outstanding at
// most; a request is accepted in IDLE, held for WAIT_CYCLES wait states and
// then answered in RESP until the requester takes the response.
// Loads and stores of BYTE/HALF/WORD size use little-endian byte lanes;
// loads are sign- or zero-extended according to the access type.
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   -> misaligned HALF/WORD accesses are rejected with rsp_err
//   undefined -> misaligned HALF/WORD accesses are force-aligned and proceed
// Memory contents are never cleared by reset.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // memAccessType_t encoding
    localparam logic [2:0] T_BYTE   = 3'd0;
    localparam logic [2:0] T_HALF   = 3'd1;
    localparam logic [2:0] T_WORD   = 3'd2;
    localparam logic [2:0] T_BYTE_U = 3'd3;
    localparam logic [2:0] T_HALF_U = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_next_s;
    logic        enter_resp_s;

    logic        lat_we_r;
    logic [31:0] lat_addr_r;
    logic [31:0] lat_wdata_r;
    logic [2:0]  lat_type_r;

    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        accept_s;
    logic        op_we_s;
    logic [31:0] op_addr_s;
    logic [31:0] op_wdata_s;
    logic [2:0]  op_type_s;
    logic [IDX_W-1:0] op_idx_s;
    logic [1:0]  op_off_s;
    logic        op_err_s;
    logic [31:0] rd_word_s;
    logic [3:0]  wr_be_s;
    logic [31:0] wr_data_s;
    logic        commit_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    // Access is rejected for bad type, unsigned store, out-of-range word or
    // (optionally) misalignment.
    function automatic logic access_err(input logic we, input logic [31:0] addr,
                                        input logic [2:0] typ);
        logic bad;
        bad = 1'b0;
        if (typ > T_HALF_U) begin
            bad = 1'b1;
        end else if (we && ((typ == T_BYTE_U) || (typ == T_HALF_U))) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
`ifdef DMEM_MISALIGN_ERR_EN
        if (((typ == T_HALF) || (typ == T_HALF_U)) && addr[0]) begin
            bad = 1'b1;
        end else if ((typ == T_WORD) && (addr[1:0] != 2'b00)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
`endif
        return bad;
    endfunction

    // Byte offset within the word actually used for the access.
    function automatic logic [1:0] lane_offset(input logic [1:0] a, input logic [2:0] typ);
`ifdef DMEM_MISALIGN_ERR_EN
        return (typ == T_WORD) ? 2'b00 : a;
`else
        case (typ)
            T_HALF, T_HALF_U: return {a[1], 1'b0};
            T_WORD:           return 2'b00;
            default:          return a;
        endcase
`endif
    endfunction

    // Byte-lane write enables for a store.
    function automatic logic [3:0] lane_enable(input logic [1:0] off, input logic [2:0] typ);
        case (typ)
            T_BYTE:  return 4'b0001 << off;
            T_HALF:  return off[1] ? 4'b1100 : 4'b0011;
            T_WORD:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Store data replicated onto every lane so the enables pick the right one.
    function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [2:0] typ);
        case (typ)
            T_BYTE:  return {4{wdata[7:0]}};
            T_HALF:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Shift the selected lane(s) down to bit 0 and extend.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] typ);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (typ)
            T_BYTE:   return {{24{sh[7]}}, sh[7:0]};
            T_HALF:   return {{16{sh[15]}}, sh[15:0]};
            T_WORD:   return word;
            T_BYTE_U: return {24'h000000, sh[7:0]};
            T_HALF_U: return {16'h0000, sh[15:0]};
            default:  return 32'h0000_0000;
        endcase
    endfunction

    assign accept_s = req_valid && req_ready_r && (state_r == IDLE);

    // Operand source: live request when answering straight from IDLE, else the latched copy.
    always_comb begin
        op_we_s    = lat_we_r;
        op_addr_s  = lat_addr_r;
        op_wdata_s = lat_wdata_r;
        op_type_s  = lat_type_r;
        if (state_r == IDLE) begin
            op_we_s    = req_we;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
            op_type_s  = req_type;
        end else begin
            op_we_s    = lat_we_r;
            op_addr_s  = lat_addr_r;
            op_wdata_s = lat_wdata_r;
            op_type_s  = lat_type_r;
        end
    end

    assign op_idx_s  = op_addr_s[IDX_W+1:2];
    assign op_off_s  = lane_offset(op_addr_s[1:0], op_type_s);
    assign op_err_s  = access_err(op_we_s, op_addr_s, op_type_s);
    assign rd_word_s = mem_r[op_idx_s];
    assign wr_be_s   = lane_enable(op_off_s, op_type_s);
    assign wr_data_s = lane_data(op_wdata_s, op_type_s);
    assign commit_s  = enter_resp_s && op_we_s && !op_err_s;

    // Next-state logic: accept in IDLE, count wait states, hold RESP until taken.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = WAIT;
                        cnt_next_s   = CNT_LOAD;
                    end else begin
                        state_next_s = RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State, wait counter and request-ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            req_ready_r <= (state_next_s == IDLE);
        end
    end

    // Capture the request at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'h0000_0000;
            lat_wdata_r <= 32'h0000_0000;
            lat_type_r  <= 3'd0;
        end else if (accept_s) begin
            lat_we_r    <= req_we;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
            lat_type_r  <= req_type;
        end
    end

    // Response registers: loaded on entering RESP, cleared by the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= op_err_s;
            rsp_rdata_r <= (op_err_s || op_we_s) ? 32'h0000_0000
                                                 : load_extract(rd_word_s, op_off_s, op_type_s);
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end
    end

    // Storage array: byte-lane store commit on the edge entering RESP, never reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_s[i]) begin
                    mem_r[op_idx_s][i*8 +: 8] <= wr_data_s[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (WAIT_CYCLES=2, DEPTH_WORDS=1024).
// Expected responses are queued when a request is driven and popped when the
// response appears. Expectations follow DMEM_MISALIGN_ERR_EN when defined.
module tb_dmem_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH_WORDS = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_w [8];

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_type  (req_type),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request starting at a negedge; returns at the negedge after the handshake.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] typ,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
        exp_t        e;
        int          guard;
        int          lat;
        logic [31:0] d0;
        logic        e0;
        e.rdata = exp_d;
        e.err   = exp_e;
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_type  = typ;
        rsp_ready = 1'b0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ".accept"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'h0000_0000;
        chk({tag, ".busy"}, 32'(req_ready), 32'd0);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        d0 = rsp_rdata;
        e0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata, d0);
            chk({tag, ".hold_err"},   32'(rsp_err), 32'(e0));
            chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        e = sb_q.pop_front();
        chk({tag, ".rdata"}, rsp_rdata, e.rdata);
        chk({tag, ".err"},   32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".idle"},     32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0000;
        req_wdata = 32'h0000_0000;
        req_type  = 3'd0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0000_0000);
        chk("rst.rsp_err",   32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_after", 32'(req_ready), 32'd1);

        // Word store/load and sub-word loads with extension
        xact("st_w10",  1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0000_0000, 1'b0, 0);
        xact("ld_w10",  1'b0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0, 0);
        xact("ld_b13",  1'b0, 32'h13, 32'h0,        3'd0, 32'hFFFFFFDE, 1'b0, 0);
        xact("ld_bu13", 1'b0, 32'h13, 32'h0,        3'd3, 32'h000000DE, 1'b0, 0);
        xact("ld_h10",  1'b0, 32'h10, 32'h0,        3'd1, 32'hFFFFBEEF, 1'b0, 0);
        xact("ld_hu12", 1'b0, 32'h12, 32'h0,        3'd4, 32'h0000DEAD, 1'b0, 0);

        // Byte store into one lane, then word readback right after the store response
        xact("st_b11",  1'b1, 32'h11, 32'hAAAAAA55, 3'd0, 32'h0000_0000, 1'b0, 0);
        xact("ld_w10b", 1'b0, 32'h10, 32'h0,        3'd2, 32'hDEAD55EF, 1'b0, 0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_ERR_EN
        xact("ld_w12",  1'b0, 32'h12, 32'h0, 3'd2, 32'h0000_0000, 1'b1, 0);
        xact("ld_h11",  1'b0, 32'h11, 32'h0, 3'd1, 32'h0000_0000, 1'b1, 0);
`else
        xact("ld_w12",  1'b0, 32'h12, 32'h0, 3'd2, 32'hDEAD55EF, 1'b0, 0);
        xact("ld_h11",  1'b0, 32'h11, 32'h0, 3'd1, 32'h000055EF, 1'b0, 0);
`endif

        // Out-of-range store must not alias onto word 0
        xact("st_w0",    1'b1, 32'h0,    32'h11112222, 3'd2, 32'h0000_0000, 1'b0, 0);
        xact("st_oor",   1'b1, 32'h4000, 32'h99999999, 3'd2, 32'h0000_0000, 1'b1, 0);
        xact("ld_oor",   1'b0, 32'h4000, 32'h0,        3'd2, 32'h0000_0000, 1'b1, 0);
        xact("ld_w0",    1'b0, 32'h0,    32'h0,        3'd2, 32'h11112222, 1'b0, 0);

        // Illegal types and unsigned stores
        xact("ld_t5",    1'b0, 32'h10, 32'h0,        3'd5, 32'h0000_0000, 1'b1, 0);
        xact("st_bu",    1'b1, 32'h10, 32'h00000077, 3'd3, 32'h0000_0000, 1'b1, 0);
        xact("st_hu",    1'b1, 32'h10, 32'h00007777, 3'd4, 32'h0000_0000, 1'b1, 0);
        xact("ld_w10c",  1'b0, 32'h10, 32'h0,        3'd2, 32'hDEAD55EF, 1'b0, 0);

        // Upper half store
        xact("st_w20",   1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 32'h0000_0000, 1'b0, 0);
        xact("st_h22",   1'b1, 32'h22, 32'h1234BEEF, 3'd1, 32'h0000_0000, 1'b0, 0);
        xact("ld_h22",   1'b0, 32'h22, 32'h0,        3'd1, 32'hFFFFBEEF, 1'b0, 0);
        xact("ld_w20",   1'b0, 32'h20, 32'h0,        3'd2, 32'hBEEFF00D, 1'b0, 0);

        // Back-pressure: response held for 5 cycles
        xact("hold_w10", 1'b0, 32'h10, 32'h0,        3'd2, 32'hDEAD55EF, 1'b0, 5);

        // Reset in the last wait cycle of a store discards it
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_type  = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("wrst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wrst.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("wrst.held_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        xact("ld_w20r",  1'b0, 32'h20, 32'h0,        3'd2, 32'hBEEFF00D, 1'b0, 0);

        // Random words across the array checked against a bench-side copy
        for (int k = 0; k < 8; k++) begin
            model_w[k] = $urandom;
            xact("rnd_st", 1'b1, 32'((100 + k * 97) * 4), model_w[k], 3'd2,
                 32'h0000_0000, 1'b0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            xact("rnd_ld", 1'b0, 32'((100 + k * 97) * 4), 32'h0, 3'd2,
                 model_w[k], 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
